// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 keyboard receiver.
//   ps2_state_t : receiver FSM states (IDLE waits for a start bit,
//                 SHIFT collects data, parity and stop bits).
//   FRAME_BITS  : bits per PS/2 frame (start, 8 data, parity, stop).
//   BIT_CNT_W   : width of the in-frame bit counter.
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ps2_state_t;

    localparam int FRAME_BITS = 11;
    localparam int BIT_CNT_W  = 4;

endpackage : ps2_pkg

// File: rtl/ps2_filter.sv
// ---------------------------------------------------------------------------
// ps2_filter
// Front end for the raw PS/2 pins: synchronises both pins into the clk
// domain, debounces the PS/2 clock and flags each falling edge of the
// debounced clock.
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   ps2_clk  in   raw PS/2 clock pin (asynchronous)
//   ps2_data in   raw PS/2 data pin (asynchronous)
//   tick     out  one-cycle pulse on a falling edge of the filtered clock
//   sdata    out  synchronised data pin, valid to sample while tick is high
// ---------------------------------------------------------------------------
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic tick,
    output logic sdata
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       r_clk_sync;
    logic [1:0]       r_data_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_filt;
    logic             r_filt_d;

    // Both pins idle high, so the synchronisers and the filtered clock reset
    // to 1 and a reset never fabricates a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_cnt       <= '0;
            r_filt      <= 1'b1;
            r_filt_d    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge value, so the two synchroniser stages stay distinct.
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
            r_filt_d    <= r_filt;

            // Run length of samples disagreeing with the filtered level; a
            // single agreeing sample restarts the count, so short glitches
            // never reach the filtered clock.
            if (r_clk_sync[1] == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_filt <= r_clk_sync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign tick  = r_filt_d & ~r_filt;
    assign sdata = r_data_sync[1];

endmodule : ps2_filter

// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx
// PS/2 keyboard frame receiver. Assembles 11-bit frames (start, d0..d7 LSB
// first, odd parity, stop) and emits one result strobe per frame. A frame
// that stalls mid-way is abandoned after TIMEOUT_CYCLES without a bit.
//
// Ports
//   clk        in   system clock (100 MHz)
//   reset      in   synchronous, active-high reset
//   ps2_clk    in   raw PS/2 clock pin (asynchronous)
//   ps2_data   in   raw PS/2 data pin (asynchronous)
//   data       out  last received byte, held until the next data update
//   valid      out  one-cycle strobe: good frame, data updated
//   parity_err out  one-cycle strobe: parity failed, data updated anyway
//   frame_err  out  one-cycle strobe: stop bit was 0, data unchanged
// ---------------------------------------------------------------------------
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]      TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]      TO_ONE     = TO_W'(1);
    localparam logic [BIT_CNT_W-1:0] CNT_ONE    = BIT_CNT_W'(1);
    // Bit count value held while the parity bit is on the wire.
    localparam logic [BIT_CNT_W-1:0] CNT_PARITY = BIT_CNT_W'(FRAME_BITS - 2);
    localparam logic [BIT_CNT_W-1:0] CNT_STOP   = BIT_CNT_W'(FRAME_BITS - 1);

    logic w_tick;
    logic w_sdata;

    ps2_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .tick     (w_tick),
        .sdata    (w_sdata)
    );

    ps2_state_t           r_state,   w_state_next;
    logic [BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_next;
    logic [7:0]           r_shift,   w_shift_next;
    logic                 r_parity,  w_parity_next;
    logic [TO_W-1:0]      r_to_cnt,  w_to_cnt_next;
    logic [7:0]           r_data,    w_data_next;
    logic                 r_valid,   w_valid_next;
    logic                 r_perr,    w_perr_next;
    logic                 r_ferr,    w_ferr_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_to_cnt  <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_parity  <= w_parity_next;
            r_to_cnt  <= w_to_cnt_next;
            r_data    <= w_data_next;
            r_valid   <= w_valid_next;
            r_perr    <= w_perr_next;
            r_ferr    <= w_ferr_next;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned and infers a latch.
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_to_cnt_next  = r_to_cnt;
        w_data_next    = r_data;
        w_valid_next   = 1'b0;
        w_perr_next    = 1'b0;
        w_ferr_next    = 1'b0;

        case (r_state)
            IDLE: begin
                w_to_cnt_next = '0;
                // A high start bit is a spurious edge and is ignored.
                if (w_tick && !w_sdata) begin
                    w_state_next   = SHIFT;
                    w_bit_cnt_next = CNT_ONE;
                end
            end

            SHIFT: begin
                // A tick beats a coincident timeout.
                if (w_tick) begin
                    w_to_cnt_next  = '0;
                    w_bit_cnt_next = r_bit_cnt + CNT_ONE;
                    if (r_bit_cnt < CNT_PARITY) begin
                        w_shift_next = {w_sdata, r_shift[7:1]};
                    end else if (r_bit_cnt == CNT_PARITY) begin
                        w_parity_next = w_sdata;
                    end else begin
                        w_state_next   = IDLE;
                        w_bit_cnt_next = '0;
                        if (!w_sdata) begin
                            w_ferr_next = 1'b1;
                        end else if (^{r_shift, r_parity}) begin
                            w_data_next  = r_shift;
                            w_valid_next = 1'b1;
                        end else begin
                            w_data_next = r_shift;
                            w_perr_next = 1'b1;
                        end
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_next   = IDLE;
                    w_bit_cnt_next = '0;
                    w_to_cnt_next  = '0;
                end else begin
                    w_to_cnt_next = r_to_cnt + TO_ONE;
                end
            end

            default: begin
                w_state_next   = IDLE;
                w_bit_cnt_next = '0;
                w_to_cnt_next  = '0;
            end
        endcase
    end

    // The bit counter never legitimately passes the stop position.
    logic w_unused_stop_ok;
    assign w_unused_stop_ok = (r_bit_cnt <= CNT_STOP);

    assign data       = r_data;
    assign valid      = r_valid;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;

endmodule : ps2_rx

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- Receives PS/2 keyboard frames from the raw `ps2_clk`/`ps2_data` pins and emits one scancode byte per frame as a single-cycle strobe.
- Sits directly downstream of the board pins and upstream of the keyboard-to-terminal translation logic in `top`.
- Handles pin synchronisation, clock glitch filtering, frame checking and stuck-frame timeout.

Parameters:
- FILTER_LEN, 8: consecutive equal synchronised samples required before the filtered PS/2 clock changes level.
- TIMEOUT_CYCLES, 200000: clk cycles without a filtered falling edge before a partial frame is abandoned (2 ms at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- data  out  8  received byte; held until the next strobe.
- valid  out  1  one-cycle strobe: `data` is good.
- parity_err  out  1  one-cycle strobe: frame complete but odd parity failed.
- frame_err  out  1  one-cycle strobe: start bit was 0 but stop bit was 0.

Behaviour:
- Interface: one clock (`clk`); `reset` is synchronous and active-high. It is sampled on the rising edge of `clk`, and all state is updated on that edge.
- Reset values: `data`=0x00, `valid`=0, `parity_err`=0, `frame_err`=0. FSM=IDLE, bit count=0, timeout counter=0, filtered clock=1.
- Synchronisation: `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser.
- Clock filter: the filtered clock takes a new level only after FILTER_LEN consecutive synchronised samples at that level.
- Edge detect: a falling edge of the filtered clock produces one "sample" tick. `ps2_data` is taken from the synchronised data at that tick.
- Frame format: 11 bits: start (0), data bits d0..d7 LSB first, odd parity, stop (1).
- FSM states:
  - IDLE: on a tick with data=0, go to SHIFT with bit count=1. On a tick with data=1, stay in IDLE (spurious start, no strobe).
  - SHIFT: on each tick, shift data into an 8-bit register at the MSB, shifting right, and increment the bit count. Ticks 2..9 load d0..d7; tick 10 loads parity; tick 11 checks the stop bit, then go to IDLE.
- Completion at tick 11, with the result in the following cycle:
  - Stop=1 and parity correct (d0..d7 plus parity contains an odd number of ones): `data` updated, `valid`=1.
  - Stop=1 and parity wrong: `data` updated, `parity_err`=1, `valid`=0.
  - Stop=0: `frame_err`=1, `data` unchanged, `valid`=0.
  - Only one strobe per frame; strobes never overlap.
- Latency: the strobe asserts exactly FILTER_LEN+3 clk cycles after the raw `ps2_clk` falling edge that carries the stop bit.
- Timeout: in SHIFT, the counter increments every cycle and clears on each tick. When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE with bit count=0 and no strobe. In IDLE the counter is held at 0.
- Glitches: a `ps2_clk` low pulse shorter than FILTER_LEN cycles produces no tick and does not disturb an in-progress frame.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values. The partial frame is discarded; the rest of that frame is then treated as bits after a spurious start.
- Simultaneous events: if a tick and a timeout occur in the same cycle, the tick wins and the counter clears.

Decomposition:
- Shared package `ps2_pkg`:
  - FSM state enum (IDLE, SHIFT).
  - FRAME_BITS=11 constant.
  - Bit-count width constant (4).
- One sub-module, `ps2_filter`:
  - Contains the 2-flop synchronisers for both pins, the FILTER_LEN debounce counter and the falling-edge detector.
  - Outputs: `tick` and `sdata`.
  - Instantiated once by `ps2_rx`.

Test Plan:
- Basic frame: `ps2_clk` half-period 50 cycles, bits 0,1,0,1,0,1,0,0,0,0,1 -> one `valid` pulse with `data`=0x15, `parity_err`=`frame_err`=0. Strobe lands FILTER_LEN+3 cycles after the 11th falling edge.
- Back-to-back: 20 frames of 0x15 with 10000-cycle gaps -> exactly 20 `valid` pulses, all with 0x15, and no error strobes.
- Parity error: frame 0x15 with parity bit=1 -> `parity_err` pulse with `data`=0x15, and no `valid` pulse.
- Framing: frame 0xA5 with correct parity (1) and stop=0 -> `frame_err` pulse, `data` keeps its previous value, and no `valid` pulse.
- Glitch and timeout:
  - 3-cycle low glitch on `ps2_clk` mid-frame of 0x1C -> `valid` with 0x1C.
  - Separately, stop after 5 bits for TIMEOUT_CYCLES+10 cycles, then send a full 0x1C frame -> one `valid` with 0x1C.
- Reset: assert `reset` for 1 cycle after bit 6 of a frame -> all outputs 0 next cycle, and no strobe from the remaining bits. The following full frame 0x29 gives `valid` with 0x29.
